// File: rtl/alu_issue_sequencer.sv
// Operand-fetch / write-back sequencer and register file in front of a
// one-cycle-latency ALU: accept -> ISSUE -> WB -> done, one instruction per 3 cycles.
module alu_issue_sequencer #(
    parameter int n  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          in_cin,
    input  logic [n-1:0]  in_imm,
    output logic [n-1:0]  alu_a,
    output logic [n-1:0]  alu_b,
    output logic [2:0]    alu_op,
    output logic          alu_cin,
    input  logic          alu_carry,
    input  logic [n-1:0]  alu_res,
    output logic          carry_flag,
    output logic          done,
    input  logic [AW-1:0] dbg_addr,
    output logic [n-1:0]  dbg_data
);

    localparam int         DEPTH  = 1 << AW;
    localparam logic [2:0] OP_LDI = 3'b110;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t          state, state_nxt;
    logic [n-1:0]    rf [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [2:0]      op_q;
    logic [n-1:0]    imm_q;
    logic            carry_q;
    logic            accept;

    assign accept   = in_valid & in_ready;
    assign dbg_data = rf[dbg_addr];

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_cin    <= 1'b0;
            carry_flag <= 1'b0;
            done       <= 1'b0;
            rd_q       <= '0;
            op_q       <= '0;
            imm_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            // Operands are registered at accept so the ALU inputs stay stable
            // for the whole instruction and until the next accept.
            if (accept) begin
                alu_a   <= rf[in_rs1];
                alu_b   <= rf[in_rs2];
                alu_op  <= in_op;
                alu_cin <= in_cin;
                rd_q    <= in_rd;
                op_q    <= in_op;
                imm_q   <= in_imm;
            end
            if (state == ISSUE) carry_q <= alu_carry;
            if (state == WB) begin
                rf[rd_q]   <= (op_q == OP_LDI) ? imm_q : alu_res;
                carry_flag <= (op_q == OP_LDI) ? 1'b0 : carry_q;
                done       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: a behavioural ALU drives it, and a register-file
// model checks directed vectors, the multi-cycle corners and random instructions.
module tb_alu_issue_sequencer;
    localparam int N  = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic          in_cin;
    logic [N-1:0]  in_imm;
    logic [N-1:0]  alu_a, alu_b;
    logic [2:0]    alu_op;
    logic          alu_cin;
    logic          alu_carry;
    logic [N-1:0]  alu_res;
    logic          carry_flag;
    logic          done;
    logic [AW-1:0] dbg_addr;
    logic [N-1:0]  dbg_data;

    int passed = 0;
    int total  = 0;

    logic [N-1:0] rf_m [8];
    logic         carry_m;

    always #5 clk = ~clk;

    alu_issue_sequencer #(.n(N), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_cin(in_cin), .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_cin(alu_cin), .alu_carry(alu_carry),
        .alu_res(alu_res), .carry_flag(carry_flag), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ALU function {carry, result}; LDI yields deliberate garbage that must be ignored.
    function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic cin);
        case (op)
            3'd0:    return {1'b0, a};
            3'd1:    return {1'b0, ~a};
            3'd2:    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
            3'd3:    return {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a & b};
            3'd6:    return {1'b1, a ^ b ^ 32'hDEAD_BEEF};
            default: return '0;
        endcase
    endfunction

    logic [N:0] alu_comb;
    assign alu_comb  = alu_fn(alu_op, alu_a, alu_b, alu_cin);
    assign alu_carry = alu_comb[N];
    always @(posedge clk) alu_res <= alu_comb[N-1:0];

    // Architectural effect of one instruction: {carry, value written to rd}.
    function automatic logic [N:0] ref_exec(input logic [2:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic cin,
                                            input logic [N-1:0] imm);
        if (op == 3'd6) return {1'b0, imm};
        return alu_fn(op, a, b, cin);
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Entered on a negedge in IDLE; returns on the negedge of the done cycle
    // (still IDLE), so consecutive calls are back-to-back accepts.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic cin, input logic [N-1:0] imm,
                             input logic hold);
        logic [N-1:0] ea, eb;
        logic [N:0]   r;
        ea = rf_m[rs1];
        eb = rf_m[rs2];
        chk("ready_idle", {31'd0, in_ready}, 1);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_cin = cin; in_imm = imm;
        @(posedge clk); @(negedge clk);
        if (!hold) in_valid = 1'b0;
        chk("issue_ready", {31'd0, in_ready}, 0);
        chk("issue_alu_a", alu_a, ea);
        chk("issue_alu_b", alu_b, eb);
        chk("issue_alu_op", {29'd0, alu_op}, {29'd0, op});
        chk("issue_alu_cin", {31'd0, alu_cin}, {31'd0, cin});
        chk("issue_done", {31'd0, done}, 0);
        @(negedge clk);
        chk("wb_ready", {31'd0, in_ready}, 0);
        chk("wb_done", {31'd0, done}, 0);
        dbg_addr = rd;
        #1;
        chk("wb_dbg_old", dbg_data, rf_m[rd]);
        @(negedge clk);
        in_valid = 1'b0;
        r = ref_exec(op, ea, eb, cin, imm);
        rf_m[rd] = r[N-1:0];
        carry_m  = r[N];
        chk("done_pulse", {31'd0, done}, 1);
        chk("done_ready", {31'd0, in_ready}, 1);
        chk("done_alu_hold", alu_a, ea);
        dbg_addr = rd;
        #1;
        chk("wb_value", dbg_data, rf_m[rd]);
        chk("carry_flag", {31'd0, carry_flag}, {31'd0, carry_m});
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [2:0]   rd, rs1, rs2;
        logic         cin;
        logic [N-1:0] imm;
        logic [N-1:0] exp_val;
        logic         exp_c;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'd6, 3'd1, 3'd0, 3'd0, 1'b0, 32'h0000_0005, 32'h0000_0005, 1'b0};
        tbl[1] = '{3'd6, 3'd2, 3'd0, 3'd0, 1'b0, 32'h0000_0003, 32'h0000_0003, 1'b0};
        tbl[2] = '{3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 32'h0,         32'h0000_0009, 1'b0};
        tbl[3] = '{3'd6, 3'd4, 3'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{3'd2, 3'd5, 3'd4, 3'd1, 1'b0, 32'h0,         32'h0000_0004, 1'b1};
        tbl[5] = '{3'd3, 3'd1, 3'd1, 3'd2, 1'b0, 32'h0,         32'h0000_0002, 1'b1};
        tbl[6] = '{3'd1, 3'd1, 3'd1, 3'd1, 1'b0, 32'h0,         32'hFFFF_FFFD, 1'b0};
        tbl[7] = '{3'd7, 3'd3, 3'd4, 3'd5, 1'b1, 32'h0,         32'h0000_0000, 1'b0};
        tbl[8] = '{3'd0, 3'd7, 3'd5, 3'd0, 1'b0, 32'h0,         32'h0000_0004, 1'b0};
        tbl[9] = '{3'd5, 3'd2, 3'd4, 3'd5, 1'b1, 32'h0,         32'h0000_0004, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_cin = 1'b0; in_imm = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        carry_m = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", {29'd0, alu_op}, 0);
        chk("rst_carry", {31'd0, carry_flag}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ready", {31'd0, in_ready}, 1);
        dbg_addr = 3'd5; #1;
        chk("rst_rf5", dbg_data, 0);

        // Directed vectors, all issued back-to-back in the done cycle.
        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].cin, tbl[i].imm, 1'b0);
            dbg_addr = tbl[i].rd; #1;
            chk($sformatf("vec%0d_val", i), dbg_data, tbl[i].exp_val);
            chk($sformatf("vec%0d_carry", i), {31'd0, carry_flag}, {31'd0, tbl[i].exp_c});
        end

        // carry_flag holds through idle cycles.
        run_instr(3'd2, 3'd6, 3'd4, 3'd4, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_carry_hold", {31'd0, carry_flag}, 1);
        chk("idle_no_done", {31'd0, done}, 0);

        // Handshake stall: in_valid held through ISSUE/WB, must execute once.
        run_instr(3'd2, 3'd7, 3'd7, 3'd1, 1'b1, '0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("stall_no_dup_done", {31'd0, done}, 0);
        end
        dbg_addr = 3'd7; #1;
        chk("stall_single_write", dbg_data, rf_m[7]);

        // Reset during WB of or r6=r1|r2.
        in_valid = 1'b1; in_op = 3'd4; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2;
        in_cin = 1'b0; in_imm = '0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        carry_m = 1'b0;
        dbg_addr = 3'd6; #1;
        chk("midrst_r6", dbg_data, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_ready", {31'd0, in_ready}, 1);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_alu_b", alu_b, 0);
        chk("midrst_alu_op", {29'd0, alu_op}, 0);
        chk("midrst_carry", {31'd0, carry_flag}, 0);
        @(negedge clk);
        chk("midrst_no_late_done", {31'd0, done}, 0);
        dbg_addr = 3'd6; #1;
        chk("midrst_r6_late", dbg_data, 0);

        // Random instructions against the register-file model.
        for (int k = 0; k < 200; k++) begin
            logic [N-1:0] imm;
            imm = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
            run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), imm, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            chk($sformatf("final_r%0d", i), dbg_data, rf_m[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Micro-sequencer and register file that sits directly upstream of the ALU stage.
- Accepts one instruction at a time over a valid/ready handshake, reads two source registers, and drives the ALU operand inputs (R2, R3, ALUop, c_in).
- Waits for the ALU's registered result (R0, one clock of latency), then writes it back into the destination register and latches the carry.
- Gives the ALU a complete operand-fetch / write-back loop for lab bring-up.

Parameters:
- n, 32, datapath width; must match the ALU's n.
- AW, 3, register address width; the file holds 2**AW registers of n bits.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  sequencer can accept an instruction.
- in_op  input  3  opcode: 000 mv, 001 not, 010 add, 011 sub, 100 or, 101 and, 110 LDI, 111 reserved.
- in_rd  input  AW  destination register.
- in_rs1  input  AW  source A, drives the ALU's R2.
- in_rs2  input  AW  source B, drives the ALU's R3.
- in_cin  input  1  carry-in for add.
- in_imm  input  n  immediate, used by LDI only.
- alu_a  output  n  to ALU R2.
- alu_b  output  n  to ALU R3.
- alu_op  output  3  to ALU ALUop.
- alu_cin  output  1  to ALU c_in.
- alu_carry  input  1  from ALU carry_output (combinational).
- alu_res  input  n  from ALU R0 (registered output).
- carry_flag  output  1  carry of the last completed instruction.
- done  output  1  one-cycle pulse: write-back has completed.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  n  combinational read of rf[dbg_addr].

Behaviour:
- Reset, applied on a rising edge while rst_n=0:
  - All 2**AW registers cleared to 0.
  - state=IDLE.
  - alu_a, alu_b, alu_op, alu_cin, carry_flag and done all cleared to 0.
- Reset mid-operation abandons the instruction: no write-back and no done pulse.
- FSM states are IDLE, ISSUE and WB. in_ready=1 only in IDLE.
- IDLE:
  - An instruction is accepted on an edge where in_valid & in_ready.
  - On that edge: alu_a<=rf[in_rs1], alu_b<=rf[in_rs2], alu_op<=in_op, alu_cin<=in_cin.
  - Also latch rd_q, op_q and imm_q; go to ISSUE.
  - in_valid=0 stays in IDLE.
- ISSUE:
  - The ALU evaluates combinationally during this cycle.
  - At the closing edge the ALU's internal register captures the result and carry_q<=alu_carry.
  - Go to WB.
- WB:
  - At the closing edge, rf[rd_q]<=alu_res, or imm_q when op_q=110.
  - carry_flag<=carry_q, or 0 for LDI.
  - done<=1 for exactly the following cycle; go to IDLE.
- Timing:
  - Latency from accept edge to write edge is 2 cycles; done is high in the cycle after the write.
  - Throughput is one instruction per 3 cycles.
  - Back-to-back accept is allowed in the cycle done is high.
- Operand hold: alu_a, alu_b, alu_op and alu_cin are registered and hold their value until the next accept. The ALU inputs therefore never glitch mid-instruction.
- Read-after-write: the source read at accept always sees the previous instruction's write-back, because the write precedes the next accept edge. No bypass is required.
- rs1, rs2 and rd may alias freely; reads use pre-write values.
- LDI (110):
  - alu_op is still driven to 110, and the ALU result is ignored.
  - Same 3-cycle timing; carry_flag is cleared.
- Reserved op 111:
  - Passed through to the ALU, which produces 0 with carry 0.
  - rd is written with 0.
- carry_flag is updated only on write-back. It holds between instructions and through idle cycles.
- alu_res is sampled only in WB. Its value in other states (including the unreset value after power-up) is don't-care.
- dbg_data is a pure combinational read. A debug read in the write cycle returns the old value.
- Arithmetic is done entirely in the ALU. The sequencer performs no width conversion; the immediate is n bits.

Test Plan:
- Reset then load:
  - Hold rst_n=0 for 2 edges, then LDI r1=0x0000_0005, LDI r2=0x0000_0003.
  - Required: each done pulse lands 3 cycles after its accept, dbg r1=5, r2=3, carry_flag=0.
- Add with carry:
  - add r3=r1+r2 with cin=1.
  - Required: alu_a=5, alu_b=3, alu_op=010 in ISSUE; r3=0x0000_0009; carry_flag=0.
- Overflow carry:
  - LDI r4=0xFFFF_FFFF, then add r5=r4+r1 with cin=0.
  - Required: r5=0x0000_0004, carry_flag=1.
- Back-to-back RAW with aliasing:
  - sub r1=r1-r2, accepted in the done cycle of the previous instruction, followed immediately by not r1=r1.
  - Required: r1=2 after the sub, then r1=0xFFFF_FFFD; in_ready=0 during ISSUE and WB.
- Handshake stall:
  - Hold in_valid=1 with ready low during WB.
  - Required: the instruction is accepted exactly once, on the IDLE edge, with no duplicate write.
- Reset mid-op:
  - Assert rst_n=0 during the WB of "or r6=r1|r2".
  - Required: r6=0, no done pulse, all outputs 0, and the sequencer in IDLE on the next cycle.
